// File: rtl/apb_master_bridge_if.sv
// Local command/response channel and APB bus bundle for apb_master_bridge.
// master = bridge side; slave = requester plus APB completer side.
`timescale 1ns/1ps
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-beat command to APB initiator: IDLE -> SETUP -> ACCESS -> DONE, one transfer at a time.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                pclk_i,
  input  logic                preset_ni,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be 1..255");
  end

  logic [1:0]            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
  logic                  rsp_err_q, rsp_err_d;
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state and next-output logic; rsp_valid is a pulse so it defaults low.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        if (bus.cmd_valid_i && cmd_ready_q) begin
          paddr_d     = bus.cmd_addr_i;
          pwrite_d    = bus.cmd_write_i;
          pwdata_d    = bus.cmd_wdata_i;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
      end
      ACCESS: begin
        if (bus.pready_i) begin
          if (!pwrite_q) rsp_rdata_d = bus.prdata_i;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = DONE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end
      DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.psel_o      = psel_q;
  assign bus.penable_o   = penable_q;
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

endmodule
